// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter (8N1, or 8E1 when UART_TX_PARITY_EN is defined).
module uart_tx_fifo #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] CNT_LOAD = 16'(CLK_DIV - 1);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [15:0]   cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          push, pop, bit_end;
`ifdef UART_TX_PARITY_EN
  logic          par;
`endif
  assign in_ready = count != (AW+1)'(FIFO_DEPTH);
  assign busy     = state != IDLE || count != '0;
  assign push     = in_valid && in_ready;
  assign bit_end  = cnt == '0;
  // A pop happens only when the line is free: idle, or on the last cycle of a stop bit.
  assign pop      = count != '0 && (state == IDLE || (state == STOP && bit_end));
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      tx    <= 1'b1;
    end else if (state == IDLE || (state == STOP && bit_end)) begin
      state <= pop ? START : IDLE;
      tx    <= !pop;
      cnt   <= pop ? CNT_LOAD : '0;
      if (pop) shreg <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
      if (pop) par <= ^mem[rd_ptr];
`endif
    end else if (!bit_end) begin
      cnt <= cnt - 16'd1;
    end else begin
      cnt <= CNT_LOAD;
      case (state)
        START: begin
          state <= DATA;
          idx   <= '0;
          tx    <= shreg[0];
        end
        DATA: begin
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state <= PARITY;
            tx    <= par;
`else
            state <= STOP;
            tx    <= 1'b1;
`endif
          end else begin
            idx   <= idx + 3'd1;
            shreg <= shreg >> 1;
            tx    <= shreg[1];
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          state <= STOP;
          tx    <= 1'b1;
        end
`endif
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: checks two uart_tx_fifo builds (CLK_DIV=4/DEPTH=4 and CLK_DIV=2/DEPTH=2) against a queue-based frame model.
module tb_uart_tx_fifo;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       rdy0, tx0, busy0, rdy1, tx1, busy1;
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] q [2][$];
  logic       act [2];
  int         ft [2];
  logic [7:0] cur [2];

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_DIV(4), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy0), .tx(tx0), .busy(busy0));
  uart_tx_fifo #(.CLK_DIV(2), .FIFO_DEPTH(2)) u1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy1), .tx(tx1), .busy(busy1));

  function automatic int div_of(input int k);
    return k == 0 ? 4 : 2;
  endfunction
  function automatic int dep_of(input int k);
    return k == 0 ? 4 : 2;
  endfunction
  function automatic int flen(input int k);
    return div_of(k) * NB;
  endfunction
  // Frame bit i: start, eight data bits LSB first, optional even parity, stop.
  function automatic logic fbit(input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (NB == 11 && i == 9) return ^d;
    return 1'b1;
  endfunction
  function automatic logic exp_tx(input int k);
    return act[k] ? fbit(cur[k], ft[k] / div_of(k)) : 1'b1;
  endfunction

  task automatic chk(input string tag, input logic got, input logic want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s got=%b exp=%b t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic r);
    logic pop;
    in_valid = v;
    in_data  = d;
    rst      = r;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        q[k].delete();
        act[k] = 1'b0;
        ft[k]  = 0;
      end else begin
        pop = (!act[k] || ft[k] == flen(k) - 1) && q[k].size() > 0;
        if (act[k]) begin
          if (ft[k] == flen(k) - 1) act[k] = 1'b0;
          else ft[k]++;
        end
        if (v && q[k].size() != dep_of(k)) q[k].push_back(d);
        if (pop) begin
          cur[k] = q[k].pop_front();
          act[k] = 1'b1;
          ft[k]  = 0;
        end
      end
    end
    @(negedge clk);
    chk("tx0", tx0, exp_tx(0));
    chk("busy0", busy0, act[0] || q[0].size() > 0);
    chk("rdy0", rdy0, q[0].size() != dep_of(0));
    chk("tx1", tx1, exp_tx(1));
    chk("busy1", busy1, act[1] || q[1].size() > 0);
    chk("rdy1", rdy1, q[1].size() != dep_of(1));
  endtask

  initial begin
    logic ok;
    logic acc;
    act = '{1'b0, 1'b0};
    ft  = '{0, 0};
    cur = '{8'h00, 8'h00};
    step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    step(0, 8'h00, 0);
    step(1, 8'h55, 0);
    for (int i = 0; i < 50; i++) step(0, 8'h00, 0);
    step(1, 8'h80, 0);
    for (int i = 0; i < 50; i++) step(0, 8'h00, 0);
    for (int b = 1; b <= 6; b++) begin
      for (int i = 0; i < 200; i++) begin
        acc = q[0].size() != dep_of(0);
        step(1, 8'(b), 0);
        if (acc) break;
      end
      if (b == 5) chk("full_rdy0", rdy0, 1'b0);
    end
    for (int i = 0; i < 300; i++) step(0, 8'h00, 0);
    step(1, 8'h11, 0);
    step(1, 8'h22, 0);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      ok = act[0] && ft[0] == flen(0) - 1 && q[0].size() == 1;
      if (!ok) step(0, 8'h00, 0);
    end
    chk("wait_pushpop", ok, 1'b1);
    step(1, 8'hA3, 0);
    chk("pushpop_rdy0", rdy0, 1'b1);
    chk("pushpop_busy0", busy0, 1'b1);
    for (int i = 0; i < 100; i++) step(0, 8'h00, 0);
    step(1, 8'hFF, 0);
    step(1, 8'h12, 0);
    step(1, 8'h34, 0);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      ok = act[0] && cur[0] == 8'hFF && ft[0] / div_of(0) == 4;
      if (!ok) step(0, 8'h00, 0);
    end
    chk("wait_bit3", ok, 1'b1);
    step(0, 8'h00, 1);
    chk("rst_tx0", tx0, 1'b1);
    chk("rst_busy0", busy0, 1'b0);
    chk("rst_rdy0", rdy0, 1'b1);
    for (int i = 0; i < 60; i++) step(0, 8'h00, 0);
    step(1, 8'h5A, 1);
    chk("rst_push_busy0", busy0, 1'b0);
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 99) < 40, 8'($urandom), $urandom_range(0, 149) == 0);
    for (int i = 0; i < 100; i++) step(0, 8'h00, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 Parameter CLK_DIV, default 16: clk cycles per serial bit; legal range 2..65535.
REQ-003 Parameter FIFO_DEPTH, default 4: byte entries buffered; power of two, 2..16.
REQ-004 Port clk input 1: system clock, the SoC clock.
REQ-005 Port rst input 1: synchronous active-high reset.
REQ-006 Port in_data input 8: byte to transmit.
REQ-007 Port in_valid input 1: in_data is valid this cycle.
REQ-008 Port in_ready output 1: FIFO can accept a byte this cycle.
REQ-009 Port tx output 1: serial line, idle high; drives the board TX pin.
REQ-010 Port busy output 1: a frame is in progress or the FIFO is non-empty.

Function
REQ-011 A byte SHALL be written to the FIFO on every edge where in_valid and in_ready are both 1; in_valid without in_ready SHALL be ignored, with no side effect.
REQ-012 in_ready SHALL equal (FIFO count != FIFO_DEPTH), derived from registered state only, with no combinational path from in_valid.
REQ-013 FIFO order SHALL be first-in first-out; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-014 Simultaneous push and pop SHALL leave the count unchanged and both bytes SHALL be handled correctly, including at count FIFO_DEPTH-1 and at count 1.
REQ-015 The FSM states SHALL be IDLE, START, DATA, PARITY (macro only) and STOP.
REQ-016 In IDLE, tx SHALL be 1; on the first edge where the FIFO is non-empty, the FSM SHALL pop the head byte into a shift register and enter START.
REQ-017 A byte written at edge N into an empty FIFO while IDLE SHALL produce tx=0 starting after edge N+1.
REQ-018 Each bit SHALL be held on tx for exactly CLK_DIV cycles, timed by a bit counter reloaded at every bit boundary.
REQ-019 Frame order SHALL be: START (0), DATA bits 0..7 LSB first, optional PARITY, STOP (1).
REQ-020 At the end of STOP, if the FIFO is non-empty, the FSM SHALL pop and enter START on the same edge, giving back-to-back frames with no idle gap; otherwise it SHALL return to IDLE.
REQ-021 busy SHALL be 1 when the state is not IDLE or the FIFO count is non-zero, and 0 otherwise.
REQ-022 tx SHALL be driven from a register; it SHALL be glitch-free.

Reset
REQ-023 On rst=1 at an edge: state IDLE, FIFO count 0, pointers 0, bit counter 0, tx=1, busy=0, in_ready=1, all from the following cycle.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately (tx=1 next cycle) and discard all buffered bytes.
REQ-025 A push presented on the same edge as rst=1 SHALL be discarded.
REQ-026 Reset SHALL be repeatable at arbitrary intervals, since the SoC is periodically reset, with no residual state carried across.

Configuration
REQ-027 Macro UART_TX_PARITY_EN: when defined, the PARITY state SHALL be included, transmitting even parity (XOR of the 8 data bits) for CLK_DIV cycles between bit 7 and STOP; frame length is 11*CLK_DIV.
REQ-028 Without UART_TX_PARITY_EN: there SHALL be no PARITY state or logic; the FSM SHALL go DATA to STOP; frame length is 10*CLK_DIV.

Verification
REQ-029 Single byte: CLK_DIV=4, no macro, push 0x55 at edge N -> tx low cycles N+1..N+4, then 1,0,1,0,1,0,1,0 each for 4 cycles, then stop high for 4 cycles, then busy=0.
REQ-030 Parity: UART_TX_PARITY_EN, CLK_DIV=4, push 0x07 -> data 1,1,1,0,0,0,0,0, parity bit 1, stop 1; total 44 cycles.
REQ-031 FIFO full: FIFO_DEPTH=4, push 6 bytes 0x01..0x06 with in_valid held -> in_ready drops after the 5th accept (one byte popped to the shifter), and all 6 bytes appear in order, back-to-back, with no idle between stop and start.
REQ-032 Simultaneous push/pop: push 0xA3 on the exact edge the FSM pops from a count-1 FIFO -> count stays 1, and 0xA3 is transmitted next.
REQ-033 Reset mid-frame: assert rst during bit 3 of 0xFF with 2 bytes queued -> tx=1, busy=0, in_ready=1 next cycle, and no further frames are sent.
REQ-034 Divider boundary: CLK_DIV=2, push 0x80 -> each bit exactly 2 cycles wide, and bit 7 = 1 is observed at cycles 17..18 after the start bit begins.
